// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard/exception controller: priority stall mask, sequenced flush with
// redirect PC, saturating stall counter. Optional stall watchdog: PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl_gen #(
    parameter int              NSTAGE     = 6,
    parameter int              DW         = 32,
    parameter int              FLUSH_LEN  = 1,
    parameter logic [DW-1:0]   EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [DW-1:0]   INT_VECTOR = 32'hBFC0_0380,
    parameter int              CNT_W      = 16,
    parameter int              WDT_LIMIT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [DW-1:0]     cp0_epc_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              flush_o,
    output logic [DW-1:0]     new_pc_o,
    output logic              flush_busy_o,
`ifdef PIPE_CTRL_STALL_WDT_EN
    output logic              wdt_timeout_o,
`endif
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_LEN - 1);

    logic [0:0]        state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [DW-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [NSTAGE-1:0] mask_s;
    logic              acc_s;
    logic              exc_s;
    logic [DW-1:0]     target_s;

    // Stage k stalling must also hold every upstream stage j < k.
    always_comb begin
        mask_s = '0;
        acc_s  = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            acc_s     = acc_s | stallreq_i[k];
            mask_s[k] = acc_s;
        end
    end

    // Redirect target decode
    always_comb begin
        exc_s = (excepttype_i != 32'h0000_0000);
        case (excepttype_i)
            32'h0000_000E: target_s = cp0_epc_i;
            32'h0000_0001: target_s = INT_VECTOR;
            default:       target_s = EXC_VECTOR;
        endcase
    end

    // Outputs and next state; outputs are forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        pc_d         = pc_q;
        stall_o      = '0;
        flush_o      = 1'b0;
        flush_busy_o = 1'b0;
        new_pc_o     = '0;
        if (!rst) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (exc_s) begin
                        flush_o  = 1'b1;
                        new_pc_o = target_s;
                        pc_d     = target_s;
                        if (FLUSH_LEN > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FLUSH_INIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        stall_o = mask_s;
                    end
                end
                FLUSH: begin
                    flush_o      = 1'b1;
                    flush_busy_o = 1'b1;
                    new_pc_o     = pc_q;
                    if (fcnt_q <= 4'd1) begin
                        state_d = RUN;
                        fcnt_d  = 4'd0;
                    end else begin
                        fcnt_d  = fcnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    fcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // Saturating profile counter of stalled cycles
    always_comb begin
        if ((stall_o != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            fcnt_q      <= 4'd0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

`ifdef PIPE_CTRL_STALL_WDT_EN
    localparam int WDT_W = $clog2(WDT_LIMIT + 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_q, wdt_d;
    logic             stalling_s;

    // Consecutive-stall run length; the timeout flag is sticky until reset.
    always_comb begin
        stalling_s = (stall_o != '0) && !flush_o;
        wdt_d      = wdt_q;
        if (stalling_s) begin
            if (int'(wdt_cnt_q) < WDT_LIMIT) begin
                wdt_cnt_d = wdt_cnt_q + 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q;
            end
            if (int'(wdt_cnt_q) + 1 >= WDT_LIMIT) begin
                wdt_d = 1'b1;
            end else begin
                wdt_d = wdt_q;
            end
        end else begin
            wdt_cnt_d = '0;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt_q <= '0;
            wdt_q     <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_q     <= wdt_d;
        end
    end

    assign wdt_timeout_o = wdt_q;
`endif

endmodule
